dctq_zigzag_buffer: RTL and testbench

- Downstream stage of the 12s x 8u quantizing multiplier.
- Collects 64 quantized 9-bit signed coefficients per 8x8 block, arriving in raster (row-major) order.
- Re-emits each block in JPEG zigzag order over a valid/ready stream for the run-length/entropy stage.
- Ping-pong double buffering, so one block is written while the previous one is drained; sustains one coefficient per clock.

---
 rtl/dctq_pkg.sv | 22 ++
 rtl/dctq_zigzag_rom.sv | 12 +
 rtl/dctq_zigzag_buffer.sv | 139 +++++++++++++
 tb/tb_dctq_zigzag_buffer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dctq_pkg.sv
// Shared constants for the zigzag reorder buffer.
// Holds the coefficient width, the block size, the index type and the JPEG zigzag table.
package dctq_pkg;

   localparam int DW    = 9;
   localparam int NCOEF = 64;

   typedef logic [5:0] idx_t;

   // Entry k is the raster address of the k-th coefficient in zigzag order.
   localparam idx_t ZZ_TABLE [NCOEF] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

endpackage

// File: rtl/dctq_zigzag_rom.sv
// Combinational zigzag lookup: maps a zigzag position to the raster address
// of the coefficient that belongs there.
module dctq_zigzag_rom
   import dctq_pkg::*;
(
   input  idx_t zz_idx,
   output idx_t raster_addr
);

   assign raster_addr = ZZ_TABLE[zz_idx];

endmodule

// File: rtl/dctq_zigzag_buffer.sv
// Ping-pong 8x8 block buffer: accepts coefficients in raster order and re-emits
// each completed block in zigzag order through a one-deep output register.
module dctq_zigzag_buffer #(
   parameter int DW = dctq_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_sob,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_sob,
   output logic          out_eob,
   output logic          sync_err
);
   import dctq_pkg::*;

   localparam idx_t LAST_IDX = idx_t'(NCOEF - 1);

   // Two banks of NCOEF entries, addressed as {bank, index}.
   logic [DW-1:0] mem_q [2*NCOEF];

   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   idx_t          wr_cnt_q, wr_cnt_d;
   idx_t          rd_cnt_q, rd_cnt_d;
   logic [1:0]    full_q, full_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_sob_q, out_sob_d;
   logic          out_eob_q, out_eob_d;
   logic          sync_err_q, sync_err_d;

   logic          in_accept;
   logic          resync;
   logic          rd_load;
   idx_t          wr_idx;
   idx_t          rd_raster;
   logic [6:0]    wr_addr;
   logic [6:0]    rd_addr;

   dctq_zigzag_rom u_zigzag_rom (
      .zz_idx      (rd_cnt_q),
      .raster_addr (rd_raster)
   );

   assign in_ready  = !full_q[wr_bank_q];
   assign in_accept = in_valid && in_ready;
   // A start marker landing mid-block restarts the block from index 0.
   assign resync    = in_accept && in_sob && (wr_cnt_q != '0);
   assign wr_idx    = resync ? '0 : wr_cnt_q;
   assign wr_addr   = {wr_bank_q, wr_idx};
   assign rd_addr   = {rd_bank_q, rd_raster};
   assign rd_load   = (!out_valid_q || out_ready) && full_q[rd_bank_q];

   always_ff @(posedge clk) begin
      if (in_accept) begin
         mem_q[wr_addr] <= in_data;
      end
   end

   always_comb begin
      wr_bank_d   = wr_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_bank_d   = rd_bank_q;
      rd_cnt_d    = rd_cnt_q;
      full_d      = full_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sob_d   = out_sob_q;
      out_eob_d   = out_eob_q;
      sync_err_d  = resync;

      if (in_accept) begin
         if (resync) begin
            wr_cnt_d = idx_t'(1);
         end else if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d          = '0;
            wr_bank_d         = !wr_bank_q;
            full_d[wr_bank_q] = 1'b1;
         end else begin
            wr_cnt_d = wr_cnt_q + idx_t'(1);
         end
      end

      // Read and write never touch the same bank's flag on one edge.
      if (rd_load) begin
         out_valid_d = 1'b1;
         out_data_d  = mem_q[rd_addr];
         out_sob_d   = (rd_cnt_q == '0);
         out_eob_d   = (rd_cnt_q == LAST_IDX);
         if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d          = '0;
            rd_bank_d         = !rd_bank_q;
            full_d[rd_bank_q] = 1'b0;
         end else begin
            rd_cnt_d = rd_cnt_q + idx_t'(1);
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         full_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sob_q   <= 1'b0;
         out_eob_q   <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         full_q      <= full_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sob_q   <= out_sob_d;
         out_eob_q   <= out_eob_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sob   = out_sob_q;
   assign out_eob   = out_eob_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_dctq_zigzag_buffer.sv
// Directed bench for the zigzag reorder buffer: reset, latency, streaming,
// backpressure, resync, random stalls and reset in the middle of traffic.
module tb_dctq_zigzag_buffer;

   localparam int DW = 9;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_sob;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_sob;
   logic          out_eob;
   logic          sync_err;

   int checks = 0;
   int errors = 0;

   int cyc;
   int first_valid;
   int sync_cnt;
   int ptr;

   logic [DW-1:0] got_data [$];
   logic          got_sob  [$];
   logic          got_eob  [$];
   int            got_cyc  [$];
   logic [DW-1:0] stim_d   [$];
   logic          stim_s   [$];

   localparam int ZZ_REF [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
   };

   always #5 clk = ~clk;

   dctq_zigzag_buffer #(.DW(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_sob    (in_sob),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sob   (out_sob),
      .out_eob   (out_eob),
      .sync_err  (sync_err)
   );

   task automatic clear_log();
      got_data.delete();
      got_sob.delete();
      got_eob.delete();
      got_cyc.delete();
      stim_d.delete();
      stim_s.delete();
      ptr         = 0;
      cyc         = 0;
      first_valid = -1;
      sync_cnt    = 0;
   endtask

   // Entered and left at a falling edge; one rising edge in between.
   task automatic drive_cycle(input logic ordy, input logic vgate, output logic acc);
      logic v;
      v         = vgate && (ptr < stim_d.size());
      in_valid  = v;
      in_sob    = v ? stim_s[ptr] : 1'b0;
      in_data   = v ? stim_d[ptr] : '0;
      out_ready = ordy;
      #1;
      acc = v && in_ready;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && ordy) begin
         got_data.push_back(out_data);
         got_sob.push_back(out_sob);
         got_eob.push_back(out_eob);
         got_cyc.push_back(cyc);
      end
      if (sync_err) sync_cnt++;
      if (acc) ptr++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      in_sob    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      clear_log();
   endtask

   task automatic test_reset();
      in_valid  = 1'b0;
      in_sob    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 000", out_data); end
      checks++; if (out_sob !== 1'b0) begin errors++; $display("FAIL reset_out_sob: got %b expected 0", out_sob); end
      checks++; if (out_eob !== 1'b0) begin errors++; $display("FAIL reset_out_eob: got %b expected 0", out_eob); end
      checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b expected 0", sync_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
      $display("test_reset: outputs cleared asynchronously, in_ready high");
      clear_log();
   endtask

   task automatic test_single_block();
      logic acc;
      int   e_cyc;
      int   guard;
      e_cyc = -1;
      guard = 0;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         stim_d.push_back(DW'(i));
         stim_s.push_back(i == 0);
      end
      while (got_data.size() < 64 && guard < 300) begin
         drive_cycle(1'b1, 1'b1, acc);
         if (acc && ptr == 64) e_cyc = cyc - 1;
         guard++;
      end
      checks++; if (got_data.size() != 64) begin errors++; $display("FAIL single_count: got %0d beats expected 64", got_data.size()); end
      checks++; if (first_valid != e_cyc + 2) begin errors++; $display("FAIL single_latency: out_valid first at cycle %0d expected %0d", first_valid, e_cyc + 2); end
      for (int k = 0; k < got_data.size() && k < 64; k++) begin
         checks++; if (got_data[k] !== DW'(ZZ_REF[k])) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, got_data[k], DW'(ZZ_REF[k])); end
         checks++; if (got_sob[k] !== (k == 0)) begin errors++; $display("FAIL single_sob[%0d]: got %b expected %b", k, got_sob[k], k == 0); end
         checks++; if (got_eob[k] !== (k == 63)) begin errors++; $display("FAIL single_eob[%0d]: got %b expected %b", k, got_eob[k], k == 63); end
      end
      $display("test_single_block: %0d beats, last input at cycle %0d, first out_valid at cycle %0d", got_data.size(), e_cyc, first_valid);
   endtask

   task automatic test_back_to_back();
      logic acc;
      int   guard;
      int   in_drop;
      logic [DW-1:0] exp_d;
      guard   = 0;
      in_drop = 0;
      do_reset();
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 64; i++) begin
            stim_d.push_back(DW'(b * 64 + i));
            stim_s.push_back(i == 0);
         end
      end
      while (got_data.size() < 192 && guard < 600) begin
         if (ptr < 192 && !in_ready) in_drop++;
         drive_cycle(1'b1, 1'b1, acc);
         guard++;
      end
      checks++; if (in_drop != 0) begin errors++; $display("FAIL b2b_in_ready: dropped %0d cycles expected 0", in_drop); end
      checks++; if (got_data.size() != 192) begin errors++; $display("FAIL b2b_count: got %0d beats expected 192", got_data.size()); end
      if (got_data.size() == 192) begin
         checks++; if (got_cyc[191] - got_cyc[0] != 191) begin errors++; $display("FAIL b2b_gap: span %0d cycles expected 191", got_cyc[191] - got_cyc[0]); end
      end
      for (int k = 0; k < got_data.size() && k < 192; k++) begin
         exp_d = DW'((k / 64) * 64 + ZZ_REF[k % 64]);
         checks++; if (got_data[k] !== exp_d) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, got_data[k], exp_d); end
      end
      $display("test_back_to_back: %0d beats in %0d cycles", got_data.size(), guard);
   endtask

   task automatic test_backpressure();
      logic acc;
      int   guard;
      int   accepts;
      logic prev_rdy;
      bit   seen_eob;
      logic [DW-1:0] exp_d;
      guard    = 0;
      accepts  = 0;
      seen_eob = 0;
      do_reset();
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 64; i++) begin
            stim_d.push_back(DW'(b * 64 + i));
            stim_s.push_back(i == 0);
         end
      end
      while (in_ready && guard < 400) begin
         drive_cycle(1'b0, 1'b1, acc);
         if (acc) accepts++;
         guard++;
      end
      checks++; if (accepts != 128) begin errors++; $display("FAIL bp_accepts: in_ready dropped after %0d expected 128", accepts); end
      for (int s = 0; s < 5; s++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== '0 || out_sob !== 1'b1) begin errors++; $display("FAIL bp_hold: valid %b data %h sob %b expected 1 000 1", out_valid, out_data, out_sob); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b expected 0", in_ready); end
         drive_cycle(1'b0, 1'b1, acc);
         if (acc) accepts++;
      end
      checks++; if (accepts != 128) begin errors++; $display("FAIL bp_stall_accepts: got %0d expected 128", accepts); end
      prev_rdy = in_ready;
      guard    = 0;
      while (got_data.size() < 192 && guard < 1000) begin
         if (!seen_eob && out_valid && out_eob) begin
            seen_eob = 1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: in_ready %b at block-1 eob expected 1", in_ready); end
            checks++; if (prev_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_early: in_ready %b before block-1 eob expected 0", prev_rdy); end
         end
         prev_rdy = in_ready;
         drive_cycle(1'b1, 1'b1, acc);
         guard++;
      end
      checks++; if (got_data.size() != 192) begin errors++; $display("FAIL bp_count: got %0d beats expected 192", got_data.size()); end
      for (int k = 0; k < got_data.size() && k < 192; k++) begin
         exp_d = DW'((k / 64) * 64 + ZZ_REF[k % 64]);
         checks++; if (got_data[k] !== exp_d) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, got_data[k], exp_d); end
      end
      $display("test_backpressure: blocked after %0d accepts, drained %0d beats", accepts, got_data.size());
   endtask

   task automatic test_resync();
      logic acc;
      logic [DW-1:0] exp_d;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         stim_d.push_back(DW'(9'h010 + i));
         stim_s.push_back(i == 0);
      end
      stim_d.push_back(9'h1FB);
      stim_s.push_back(1'b1);
      for (int i = 1; i < 64; i++) begin
         stim_d.push_back(DW'(9'h100 + i));
         stim_s.push_back(1'b0);
      end
      repeat (250) drive_cycle(1'b1, 1'b1, acc);
      checks++; if (sync_cnt != 1) begin errors++; $display("FAIL resync_pulses: got %0d expected 1", sync_cnt); end
      checks++; if (got_data.size() != 64) begin errors++; $display("FAIL resync_count: got %0d beats expected 64", got_data.size()); end
      if (got_data.size() == 64) begin
         checks++; if (got_data[0] !== 9'h1FB || got_sob[0] !== 1'b1) begin errors++; $display("FAIL resync_dc: got %h sob %b expected 1fb sob 1", got_data[0], got_sob[0]); end
         for (int k = 1; k < 64; k++) begin
            exp_d = (ZZ_REF[k] == 0) ? 9'h1FB : DW'(9'h100 + ZZ_REF[k]);
            checks++; if (got_data[k] !== exp_d) begin errors++; $display("FAIL resync_data[%0d]: got %h expected %h", k, got_data[k], exp_d); end
         end
      end
      $display("test_resync: sync_err pulses %0d, %0d beats emitted", sync_cnt, got_data.size());
   endtask

   task automatic test_random();
      logic acc;
      logic ordy;
      logic vg;
      logic stalled;
      logic [DW-1:0] sd;
      logic ss;
      logic se;
      int   guard;
      int   stall_cnt;
      logic [DW-1:0] blk [8][64];
      logic [DW-1:0] exp_d;
      int   b;
      int   k;
      guard     = 0;
      stall_cnt = 0;
      stalled   = 1'b0;
      sd        = '0;
      ss        = 1'b0;
      se        = 1'b0;
      do_reset();
      for (int bb = 0; bb < 8; bb++) begin
         for (int i = 0; i < 64; i++) begin
            blk[bb][i] = DW'($urandom_range(0, 511));
            stim_d.push_back(blk[bb][i]);
            stim_s.push_back(i == 0);
         end
      end
      while (got_data.size() < 512 && guard < 5000) begin
         if (stalled) begin
            stall_cnt++;
            checks++; if (out_valid !== 1'b1 || out_data !== sd || out_sob !== ss || out_eob !== se) begin errors++; $display("FAIL rand_stall_hold: got %b %h %b %b expected 1 %h %b %b", out_valid, out_data, out_sob, out_eob, sd, ss, se); end
         end
         ordy    = 1'($urandom_range(0, 1));
         vg      = ($urandom_range(0, 3) != 0);
         stalled = out_valid && !ordy;
         sd      = out_data;
         ss      = out_sob;
         se      = out_eob;
         drive_cycle(ordy, vg, acc);
         guard++;
      end
      checks++; if (got_data.size() != 512) begin errors++; $display("FAIL rand_count: got %0d beats expected 512", got_data.size()); end
      for (int n = 0; n < got_data.size() && n < 512; n++) begin
         b     = n / 64;
         k     = n % 64;
         exp_d = blk[b][ZZ_REF[k]];
         checks++; if (got_data[n] !== exp_d) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, got_data[n], exp_d); end
         checks++; if ({got_sob[n], got_eob[n]} !== {k == 0, k == 63}) begin errors++; $display("FAIL rand_flags[%0d]: got %b%b expected %b%b", n, got_sob[n], got_eob[n], k == 0, k == 63); end
      end
      $display("test_random: %0d beats, %0d stalled cycles, %0d cycles", got_data.size(), stall_cnt, guard);
   endtask

   task automatic test_reset_mid();
      logic acc;
      int   guard;
      logic [DW-1:0] exp_d;
      guard = 0;
      do_reset();
      for (int i = 0; i < 64; i++) begin
         stim_d.push_back(DW'(9'h100 | i));
         stim_s.push_back(i == 0);
      end
      for (int i = 0; i < 40; i++) begin
         stim_d.push_back(DW'(9'h0C0 + i));
         stim_s.push_back(i == 0);
      end
      while (ptr < 104 && guard < 400) begin
         drive_cycle(1'b1, 1'b1, acc);
         guard++;
      end
      checks++; if (out_valid !== 1'b1 || out_data === '0) begin errors++; $display("FAIL mid_pre_state: valid %b data %h expected valid 1 with nonzero data", out_valid, out_data); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_out_data: got %h expected 000", out_data); end
      checks++; if (out_sob !== 1'b0 || out_eob !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL mid_flags: sob %b eob %b sync_err %b expected 0 0 0", out_sob, out_eob, sync_err); end
      in_valid  = 1'b0;
      in_sob    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
      clear_log();
      for (int i = 0; i < 64; i++) begin
         stim_d.push_back(DW'(300 - i));
         stim_s.push_back(i == 0);
      end
      repeat (200) drive_cycle(1'b1, 1'b1, acc);
      checks++; if (got_data.size() != 64) begin errors++; $display("FAIL mid_count: got %0d beats expected 64", got_data.size()); end
      for (int k = 0; k < got_data.size() && k < 64; k++) begin
         exp_d = DW'(300 - ZZ_REF[k]);
         checks++; if (got_data[k] !== exp_d) begin errors++; $display("FAIL mid_data[%0d]: got %h expected %h", k, got_data[k], exp_d); end
      end
      $display("test_reset_mid: %0d beats emitted after reset", got_data.size());
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_sob    = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      clear_log();
      test_reset();
      test_single_block();
      test_back_to_back();
      test_backpressure();
      test_resync();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
